// File: rtl/bp_train_scheduler.sv
// Training scheduler for branch_predictor: buffers resolved branches from two execute ports in an
// in-order FIFO and drains one per cycle, giving mispredict GHR recovery strict priority.
module bp_train_scheduler #(
    parameter int GH    = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       res0_valid_i,
    input  logic [31:0]                res0_pc_i,
    input  logic [31:0]                res0_target_i,
    input  logic                       res0_taken_i,
    input  logic [GH-1:0]              res0_ghr_i,
    input  logic                       res1_valid_i,
    input  logic [31:0]                res1_pc_i,
    input  logic [31:0]                res1_target_i,
    input  logic                       res1_taken_i,
    input  logic [GH-1:0]              res1_ghr_i,
    output logic                       res_ready_o,
    input  logic                       mispred_valid_i,
    input  logic [GH-1:0]              mispred_ghr_i,
    output logic                       train_valid_o,
    output logic [31:0]                train_pc_o,
    output logic [31:0]                train_actual_target_o,
    output logic                       train_actual_taken_o,
    output logic [GH-1:0]              train_ghr_snapshot_o,
    output logic                       recover_mispredict_pulse_o,
    output logic [GH-1:0]              recover_ghr_snapshot_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 65 + GH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr1_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic          ready;
    logic          push0;
    logic          push1;
    logic          do_pop;
    logic [CW-1:0] count_next;
    logic [EW-1:0] head;

    assign ready       = (count <= CW'(DEPTH - 2));
    assign res_ready_o = ready;
    assign push0       = ready && res0_valid_i;
    assign push1       = ready && res1_valid_i;
    assign do_pop      = !mispred_valid_i && (count != '0);
    assign wr1_ptr     = wr_ptr + AW'(push0);
    assign count_next  = count - CW'(do_pop) + CW'(push0) + CW'(push1);
    assign head        = mem[rd_ptr];

    assign count_o                    = count;
    assign train_valid_o              = (state == S_DRAIN);
    assign recover_mispredict_pulse_o = (state == S_RECOVER);

    always_comb begin
        next_state = S_IDLE;
        if (mispred_valid_i) begin
            next_state = S_RECOVER;
        end else if (count != '0) begin
            next_state = S_DRAIN;
        end
    end

    // Storage carries no reset; occupancy alone decides which slots hold live entries.
    always_ff @(posedge clock) begin
        if (push0) begin
            mem[wr_ptr] <= {res0_pc_i, res0_target_i, res0_taken_i, res0_ghr_i};
        end
        if (push1) begin
            mem[wr1_ptr] <= {res1_pc_i, res1_target_i, res1_taken_i, res1_ghr_i};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= S_IDLE;
            count                  <= '0;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            overflow_o             <= 1'b0;
            train_pc_o             <= '0;
            train_actual_target_o  <= '0;
            train_actual_taken_o   <= 1'b0;
            train_ghr_snapshot_o   <= '0;
            recover_ghr_snapshot_o <= '0;
        end else begin
            state  <= next_state;
            count  <= count_next;
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            if (!ready && (res0_valid_i || res1_valid_i)) begin
                overflow_o <= 1'b1;
            end
            if (mispred_valid_i) begin
                recover_ghr_snapshot_o <= mispred_ghr_i;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {train_pc_o, train_actual_target_o, train_actual_taken_o, train_ghr_snapshot_o} <= head;
            end
        end
    end
endmodule
